// File: rtl/video_mode_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : video_mode_scheduler
//  Description : Chooses which DIP pipeline drives the LCD. A debounced mode
//                push-button queues a mode change. The change is committed only
//                at a camera frame boundary. RGB is blanked for a programmable
//                number of frames after each commit so no torn frame is shown.
//  Revision    : 1.0 - initial release
// ============================================================================
module video_mode_scheduler #(
    parameter int NUM_MODES       = 4,
    parameter int DEFAULT_MODE    = 0,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int MUTE_FRAMES     = 1
) (
    input  logic                                    PixelClk,
    input  logic                                    reset,
    input  logic                                    Mode_Button,
    input  logic                                    vsync,
    input  logic [NUM_MODES-1:0]                    pipe_de,
    input  logic [NUM_MODES-1:0]                    pipe_hsync,
    input  logic [NUM_MODES-1:0]                    pipe_vsync,
    input  logic [16*NUM_MODES-1:0]                 pipe_rgb,
    output logic                                    LCD_DE,
    output logic                                    LCD_HSYNC,
    output logic                                    LCD_VSYNC,
    output logic [4:0]                              LCD_R,
    output logic [5:0]                              LCD_G,
    output logic [4:0]                              LCD_B,
    output logic [$clog2(NUM_MODES)-1:0]            mode_sel,
    output logic                                    switching
);

    // ------------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------------
    localparam int MW       = $clog2(NUM_MODES);
    localparam int DW       = $clog2(DEBOUNCE_CYCLES);
    localparam int MUTE_CW  = (MUTE_FRAMES > 1) ? $clog2(MUTE_FRAMES) : 1;
    localparam int MUTE_LST = (MUTE_FRAMES > 0) ? (MUTE_FRAMES - 1) : 0;

    localparam logic [MW-1:0]      c_default_mode = MW'(DEFAULT_MODE);
    localparam logic [MW-1:0]      c_last_mode    = MW'(NUM_MODES - 1);
    localparam logic [DW-1:0]      c_deb_last     = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [MUTE_CW-1:0] c_mute_last    = MUTE_CW'(MUTE_LST);
    localparam logic               c_no_mute      = (MUTE_FRAMES == 0);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_ARMED = 2'd1,
        ST_MUTE  = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Signal declarations
    // ------------------------------------------------------------------------
    logic                 r_btn_meta;
    logic                 r_btn_sync;
    logic                 r_db_level;
    logic [DW-1:0]        r_db_cnt;
    logic                 w_db_flip;
    logic                 w_press;

    logic                 r_vsync_q;
    logic                 w_fe;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [MW-1:0]        r_mode;
    logic [MW-1:0]        w_mode_nxt;
    logic [MW-1:0]        r_pend;
    logic [MW-1:0]        w_pend_nxt;
    logic                 r_pend_v;
    logic                 w_pend_v_nxt;
    logic [MUTE_CW-1:0]   r_mute_cnt;
    logic [MUTE_CW-1:0]   w_mute_cnt_nxt;
    logic [MW-1:0]        w_base;
    logic                 r_switching;
    logic                 w_switching_nxt;

    logic [15:0]          w_rgb_sel;
    logic                 w_muted;

    // Modulo-NUM_MODES increment; NUM_MODES need not be a power of two.
    function automatic logic [MW-1:0] f_inc(input logic [MW-1:0] x);
        if (x == c_last_mode) begin
            return '0;
        end
        return x + MW'(1);
    endfunction

    // ------------------------------------------------------------------------
    // Button path: two-flop synchronizer followed by a stability counter.
    // The debounced level is active-low; out of reset it reads "released" (1).
    // ------------------------------------------------------------------------
    assign w_db_flip = (r_btn_sync != r_db_level) && (r_db_cnt == c_deb_last);
    // A press is the debounced 1->0 transition; release produces nothing.
    assign w_press   = w_db_flip && r_db_level;

    // Synchronize the raw button and accept a new level only once it is stable.
    always_ff @(posedge PixelClk or negedge reset) begin
        if (!reset) begin
            r_btn_meta <= 1'b1;
            r_btn_sync <= 1'b1;
            r_db_level <= 1'b1;
            r_db_cnt   <= '0;
        end else begin
            r_btn_meta <= Mode_Button;
            r_btn_sync <= r_btn_meta;
            if (r_btn_sync == r_db_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_deb_last) begin
                r_db_level <= r_btn_sync;
                r_db_cnt   <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DW'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Frame boundary: rising edge of the camera vsync.
    // ------------------------------------------------------------------------
    assign w_fe = vsync & ~r_vsync_q;

    // Delay vsync by one cycle for edge detection.
    always_ff @(posedge PixelClk or negedge reset) begin
        if (!reset) begin
            r_vsync_q <= 1'b0;
        end else begin
            r_vsync_q <= vsync;
        end
    end

    // ------------------------------------------------------------------------
    // Scheduler state register, committed mode, pending target, mute counter.
    // ------------------------------------------------------------------------
    // Hold the scheduler state; everything returns to defaults on reset.
    always_ff @(posedge PixelClk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_RUN;
            r_mode      <= c_default_mode;
            r_pend      <= '0;
            r_pend_v    <= 1'b0;
            r_mute_cnt  <= '0;
            r_switching <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mode      <= w_mode_nxt;
            r_pend      <= w_pend_nxt;
            r_pend_v    <= w_pend_v_nxt;
            r_mute_cnt  <= w_mute_cnt_nxt;
            r_switching <= w_switching_nxt;
        end
    end

    // Next-state logic: frame events are resolved first, then a press in the
    // same cycle builds on whatever the frame event left behind.
    always_comb begin
        w_state_nxt     = r_state;
        w_mode_nxt      = r_mode;
        w_pend_nxt      = r_pend;
        w_pend_v_nxt    = r_pend_v;
        w_mute_cnt_nxt  = r_mute_cnt;
        w_base          = r_mode;
        w_switching_nxt = 1'b0;

        case (r_state)
            ST_RUN: begin
                // Nothing to do until a press arrives (handled below).
            end
            ST_ARMED: begin
                if (w_fe) begin
                    w_pend_v_nxt = 1'b0;
                    if (r_pend == r_mode) begin
                        // Presses came full circle: no visible change, no mute.
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_mode_nxt     = r_pend;
                        w_mute_cnt_nxt = '0;
                        w_state_nxt    = c_no_mute ? ST_RUN : ST_MUTE;
                    end
                end
            end
            ST_MUTE: begin
                if (w_fe) begin
                    if (r_mute_cnt == c_mute_last) begin
                        w_mute_cnt_nxt = '0;
                        w_state_nxt    = r_pend_v ? ST_ARMED : ST_RUN;
                    end else begin
                        w_mute_cnt_nxt = r_mute_cnt + MUTE_CW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt  = ST_RUN;
                w_pend_v_nxt = 1'b0;
            end
        endcase

        // A press advances the pending target from the newest reference:
        // the pending value if one is live, otherwise the committed mode.
        if (w_press) begin
            w_base       = w_pend_v_nxt ? w_pend_nxt : w_mode_nxt;
            w_pend_nxt   = f_inc(w_base);
            w_pend_v_nxt = 1'b1;
            if (w_state_nxt == ST_RUN) begin
                w_state_nxt = ST_ARMED;
            end
        end

        w_switching_nxt = (w_state_nxt != ST_RUN);
    end

    assign mode_sel  = r_mode;
    assign switching = r_switching;

    // ------------------------------------------------------------------------
    // Output mux: one register stage. The mute flag is taken from the same
    // state register as mode_sel, so the first pixel of a new mode is black.
    // ------------------------------------------------------------------------
    assign w_rgb_sel = pipe_rgb[16*r_mode +: 16];
    assign w_muted   = (r_state == ST_MUTE);

    // Register the selected pipeline onto the LCD pins, blanking RGB in mute.
    always_ff @(posedge PixelClk or negedge reset) begin
        if (!reset) begin
            LCD_DE    <= 1'b0;
            LCD_HSYNC <= 1'b0;
            LCD_VSYNC <= 1'b0;
            LCD_R     <= '0;
            LCD_G     <= '0;
            LCD_B     <= '0;
        end else begin
            LCD_DE    <= pipe_de[r_mode];
            LCD_HSYNC <= pipe_hsync[r_mode];
            LCD_VSYNC <= pipe_vsync[r_mode];
            if (w_muted) begin
                LCD_R <= '0;
                LCD_G <= '0;
                LCD_B <= '0;
            end else begin
                LCD_R <= w_rgb_sel[15:11];
                LCD_G <= w_rgb_sel[10:5];
                LCD_B <= w_rgb_sel[4:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_video_mode_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_mode_scheduler
//  Description : Self-checking bench for video_mode_scheduler. Pixel traffic
//                is checked through an expected-value queue; control
//                behaviour is checked inline by per-scenario tasks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_video_mode_scheduler;

    localparam int NUM_MODES = 4;
    localparam int DEB       = 8;
    localparam int MUTE      = 1;

    logic        PixelClk    = 1'b0;
    logic        reset       = 1'b1;
    logic        Mode_Button = 1'b1;
    logic        vsync       = 1'b0;
    logic [3:0]  pipe_de     = '0;
    logic [3:0]  pipe_hsync  = '0;
    logic [3:0]  pipe_vsync  = '0;
    logic [63:0] pipe_rgb    = '0;
    logic        LCD_DE, LCD_HSYNC, LCD_VSYNC;
    logic [4:0]  LCD_R;
    logic [5:0]  LCD_G;
    logic [4:0]  LCD_B;
    logic [1:0]  mode_sel;
    logic        switching;

    video_mode_scheduler #(
        .NUM_MODES       (NUM_MODES),
        .DEFAULT_MODE    (0),
        .DEBOUNCE_CYCLES (DEB),
        .MUTE_FRAMES     (MUTE)
    ) dut (
        .PixelClk    (PixelClk),
        .reset       (reset),
        .Mode_Button (Mode_Button),
        .vsync       (vsync),
        .pipe_de     (pipe_de),
        .pipe_hsync  (pipe_hsync),
        .pipe_vsync  (pipe_vsync),
        .pipe_rgb    (pipe_rgb),
        .LCD_DE      (LCD_DE),
        .LCD_HSYNC   (LCD_HSYNC),
        .LCD_VSYNC   (LCD_VSYNC),
        .LCD_R       (LCD_R),
        .LCD_G       (LCD_G),
        .LCD_B       (LCD_B),
        .mode_sel    (mode_sel),
        .switching   (switching)
    );

    always #5 PixelClk = ~PixelClk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [18:0] val;
        int          due;
    } sb_t;
    sb_t sbq[$];
    sb_t mon_item;

    always @(posedge PixelClk) cyc <= cyc + 1;

    // Scoreboard: compare every queued pixel once its output cycle arrives.
    always @(negedge PixelClk) begin
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            mon_item = sbq.pop_front();
            checks++;
            if ({LCD_DE, LCD_HSYNC, LCD_VSYNC, LCD_R, LCD_G, LCD_B} !== mon_item.val) begin
                errors++;
                $display("FAIL lcd_pixel cycle %0d got %h expected %h", cyc,
                         {LCD_DE, LCD_HSYNC, LCD_VSYNC, LCD_R, LCD_G, LCD_B}, mon_item.val);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge PixelClk);
        #1;
    endtask

    // Drive random pipeline data and queue the LCD word expected next cycle.
    task automatic drive_pix(input int em, input bit muted);
        sb_t it;
        logic [15:0] rgb;
        pipe_de    = 4'($urandom);
        pipe_hsync = 4'($urandom);
        pipe_vsync = 4'($urandom);
        pipe_rgb   = {$urandom, $urandom};
        rgb        = pipe_rgb[em*16 +: 16];
        it.val     = {pipe_de[em], pipe_hsync[em], pipe_vsync[em], muted ? 16'h0000 : rgb};
        it.due     = cyc + 1;
        sbq.push_back(it);
    endtask

    task automatic pix_cycles(input int n, input int em, input bit muted);
        repeat (n) begin
            drive_pix(em, muted);
            step(1);
        end
    endtask

    task automatic do_press();
        Mode_Button = 1'b0;
        step(20);
        Mode_Button = 1'b1;
        step(20);
    endtask

    task automatic test_reset();
        pipe_de = '1; pipe_hsync = '1; pipe_vsync = '1; pipe_rgb = '1;
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({LCD_DE, LCD_HSYNC, LCD_VSYNC, LCD_R, LCD_G, LCD_B} !== 19'h0) begin
            errors++;
            $display("FAIL reset_lcd got %h expected 0", {LCD_DE, LCD_HSYNC, LCD_VSYNC, LCD_R, LCD_G, LCD_B});
        end
        step(3);
        checks++;
        if (mode_sel !== 2'd0 || switching !== 1'b0 || LCD_DE !== 1'b0 || {LCD_R, LCD_G, LCD_B} !== 16'h0) begin
            errors++;
            $display("FAIL reset_hold mode_sel %0d switching %b de %b rgb %h expected 0 0 0 0",
                     mode_sel, switching, LCD_DE, {LCD_R, LCD_G, LCD_B});
        end
        reset = 1'b1;
        pipe_rgb = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        pipe_de = '0; pipe_hsync = '0; pipe_vsync = '0;
        step(1);
        checks++;
        if ({LCD_R, LCD_G, LCD_B} !== 16'h1111 || mode_sel !== 2'd0) begin
            errors++;
            $display("FAIL default_mode rgb %h mode_sel %0d expected 1111 0", {LCD_R, LCD_G, LCD_B}, mode_sel);
        end
    endtask

    task automatic test_debounce();
        bit seen = 1'b0;
        int lat  = 0;
        Mode_Button = 1'b0;
        step(5);
        Mode_Button = 1'b1;
        for (int k = 0; k < 30; k++) begin
            step(1);
            if (switching) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL short_glitch switching rose got 1 expected 0");
        end
        Mode_Button = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            step(1);
            if (switching) begin
                lat = k;
                break;
            end
        end
        checks++;
        if (lat != DEB + 2) begin
            errors++;
            $display("FAIL press_latency got %0d cycles expected %0d (0 = timeout)", lat, DEB + 2);
        end
        if (lat > 0 && lat < 20) step(20 - lat);
        Mode_Button = 1'b1;
        step(20);
        checks++;
        if (switching !== 1'b1 || mode_sel !== 2'd0) begin
            errors++;
            $display("FAIL armed_hold switching %b mode_sel %0d expected 1 0", switching, mode_sel);
        end
    endtask

    task automatic test_full_circle();
        repeat (3) do_press();
        checks++;
        if (switching !== 1'b1) begin
            errors++;
            $display("FAIL circle_armed switching got %b expected 1", switching);
        end
        vsync = 1'b1;
        drive_pix(0, 1'b0);
        step(1);
        checks++;
        if (mode_sel !== 2'd0 || switching !== 1'b0) begin
            errors++;
            $display("FAIL circle_commit mode_sel %0d switching %b expected 0 0", mode_sel, switching);
        end
        pix_cycles(3, 0, 1'b0);
        vsync = 1'b0;
        pix_cycles(5, 0, 1'b0);
    endtask

    task automatic test_frame_commit();
        do_press();
        checks++;
        if (switching !== 1'b1 || mode_sel !== 2'd0) begin
            errors++;
            $display("FAIL commit_armed switching %b mode_sel %0d expected 1 0", switching, mode_sel);
        end
        pix_cycles(5, 0, 1'b0);
        vsync = 1'b1;
        drive_pix(0, 1'b0);
        step(1);
        checks++;
        if (mode_sel !== 2'd1) begin
            errors++;
            $display("FAIL commit_mode got %0d expected 1", mode_sel);
        end
        pix_cycles(3, 1, 1'b1);
        vsync = 1'b0;
        pix_cycles(20, 1, 1'b1);
        checks++;
        if (switching !== 1'b1) begin
            errors++;
            $display("FAIL mute_switching got %b expected 1", switching);
        end
        vsync = 1'b1;
        drive_pix(1, 1'b1);
        step(1);
        checks++;
        if (switching !== 1'b0) begin
            errors++;
            $display("FAIL mute_end switching got %b expected 0", switching);
        end
        pipe_rgb = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        step(1);
        checks++;
        if ({LCD_R, LCD_G, LCD_B} !== 16'h2222) begin
            errors++;
            $display("FAIL mode1_rgb got %h expected 2222", {LCD_R, LCD_G, LCD_B});
        end
        pix_cycles(2, 1, 1'b0);
        vsync = 1'b0;
        step(3);
    endtask

    task automatic test_back_to_back();
        do_press();
        vsync = 1'b1;
        step(1);
        checks++;
        if (mode_sel !== 2'd2) begin
            errors++;
            $display("FAIL b2b_mode2 got %0d expected 2", mode_sel);
        end
        step(3);
        vsync = 1'b0;
        step(10);
        vsync = 1'b1;
        step(4);
        vsync = 1'b0;
        step(5);
        do_press();
        checks++;
        if (switching !== 1'b1 || mode_sel !== 2'd2) begin
            errors++;
            $display("FAIL b2b_armed switching %b mode_sel %0d expected 1 2", switching, mode_sel);
        end
        // Press qualifies DEB+2 edges after the drop; place the frame edge on that cycle.
        Mode_Button = 1'b0;
        step(DEB + 1);
        vsync = 1'b1;
        drive_pix(2, 1'b0);
        step(1);
        checks++;
        if (mode_sel !== 2'd3 || switching !== 1'b1) begin
            errors++;
            $display("FAIL b2b_commit3 mode_sel %0d switching %b expected 3 1", mode_sel, switching);
        end
        pix_cycles(3, 3, 1'b1);
        vsync = 1'b0;
        step(11);
        Mode_Button = 1'b1;
        pix_cycles(20, 3, 1'b1);
        vsync = 1'b1;
        drive_pix(3, 1'b1);
        step(1);
        checks++;
        if (mode_sel !== 2'd3 || switching !== 1'b1) begin
            errors++;
            $display("FAIL b2b_rearm mode_sel %0d switching %b expected 3 1", mode_sel, switching);
        end
        pix_cycles(3, 3, 1'b0);
        vsync = 1'b0;
        pix_cycles(10, 3, 1'b0);
        vsync = 1'b1;
        drive_pix(3, 1'b0);
        step(1);
        checks++;
        if (mode_sel !== 2'd0 || switching !== 1'b1) begin
            errors++;
            $display("FAIL b2b_commit0 mode_sel %0d switching %b expected 0 1", mode_sel, switching);
        end
        pix_cycles(3, 0, 1'b1);
        vsync = 1'b0;
        step(5);
    endtask

    task automatic test_reset_mid();
        vsync = 1'b1;
        step(4);
        vsync = 1'b0;
        step(3);
        do_press();
        vsync = 1'b1;
        step(1);
        checks++;
        if (mode_sel !== 2'd1 || switching !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_mode mode_sel %0d switching %b expected 1 1", mode_sel, switching);
        end
        step(3);
        vsync = 1'b0;
        step(3);
        do_press();
        pipe_de = '1; pipe_hsync = '1; pipe_vsync = '1; pipe_rgb = '1;
        step(2);
        checks++;
        if (LCD_DE !== 1'b1 || {LCD_R, LCD_G, LCD_B} !== 16'h0 || switching !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_mute de %b rgb %h switching %b expected 1 0 1", LCD_DE, {LCD_R, LCD_G, LCD_B}, switching);
        end
        #3 reset = 1'b0;
        #1;
        checks++;
        if ({LCD_DE, LCD_HSYNC, LCD_VSYNC, LCD_R, LCD_G, LCD_B} !== 19'h0 || mode_sel !== 2'd0 || switching !== 1'b0) begin
            errors++;
            $display("FAIL async_reset lcd %h mode_sel %0d switching %b expected 0 0 0",
                     {LCD_DE, LCD_HSYNC, LCD_VSYNC, LCD_R, LCD_G, LCD_B}, mode_sel, switching);
        end
        step(2);
        reset = 1'b1;
        for (int f = 0; f < 3; f++) begin
            vsync = 1'b1;
            step(4);
            vsync = 1'b0;
            step(6);
            checks++;
            if (mode_sel !== 2'd0 || switching !== 1'b0) begin
                errors++;
                $display("FAIL post_reset frame %0d mode_sel %0d switching %b expected 0 0", f, mode_sel, switching);
            end
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d expected 0", sbq.size());
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_full_circle();
        test_frame_commit();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
